// File: rtl/ovf_evt_pkg.sv
// ovf_evt_pkg: shared types and helpers for the overflow event FIFO.
//   ovf_evt_t  : packed event record {dir, ts} at the default timestamp width
//   DIR_UP     : direction code for an up-wrap (count wrapped to 0)
//   DIR_DOWN   : direction code for a down-wrap (count wrapped to all-ones)
//   lvl_w()    : width of a 0..DEPTH occupancy count
package ovf_evt_pkg;

  localparam int EVT_TS_W = 16;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic                dir;
    logic [EVT_TS_W-1:0] ts;
  } ovf_evt_t;

  // One extra bit so that a completely full FIFO (level == DEPTH) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ovf_evt_sync_fifo.sv
// ovf_evt_sync_fifo: single-clock FIFO for event records (an ovf_evt_t by default).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : write request; wr_data : record to write
//   wr_accept  : write taken this cycle (not full, or full with a simultaneous read)
//   rd_en      : read request; ignored while empty
//   rd_valid   : head holds a valid record; rd_data : registered head record
//   level      : registered number of stored records; full : level == DEPTH
// The head record is held in its own register so that it is stable while no
// read happens, keeps its last value while empty, and is zero during reset.
module ovf_evt_sync_fifo
  import ovf_evt_pkg::*;
#(
  parameter int DATA_W = $bits(ovf_evt_t),
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_accept,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              rd_fire;
  logic              wr_fire;

  always_comb begin
    rd_fire  = rd_en && (level_q != '0);
    wr_fire  = wr_en && (!full_q || rd_fire);
    wr_ptr_d = wr_ptr_q + PW'(wr_fire);
    rd_ptr_d = rd_ptr_q + PW'(rd_fire);

    level_d = level_q;
    if (wr_fire && !rd_fire) begin
      level_d = level_q + PW'(1);
    end else if (!wr_fire && rd_fire) begin
      level_d = level_q - PW'(1);
    end
    full_d = (level_d == PW'(DEPTH));

    // Next head: if the new read pointer lands on the slot being written this
    // cycle, the record being written is the only entry and bypasses memory.
    // Full-width pointer compare keeps a full FIFO from matching.
    head_d = head_q;
    if (level_d != '0) begin
      if (rd_ptr_d == wr_ptr_q) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign wr_accept = wr_fire;
  assign rd_valid  = (level_q != '0);
  assign rd_data   = head_q;
  assign level     = level_q;
  assign full      = full_q;

endmodule

// File: rtl/overflow_event_fifo.sv
// overflow_event_fifo: captures counter wrap events, tags them with direction
// and a free-running timestamp, and queues them for a valid/ready consumer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   count     : monitored counter value (N bits)
//   overflow  : counter wrap pulse
//   ev_valid / ev_ready : head-of-queue handshake
//   ev_dir    : head direction (1 = up-wrap, 0 = down-wrap)
//   ev_ts     : head timestamp (TS_W bits)
//   level     : stored entries; full : level == DEPTH
//   drop_cnt  : saturating count of events lost to a full queue
// Build option: OVF_EVT_DROP_CNT_EN enables the drop counter; when undefined,
// drop_cnt is tied to zero and events are still dropped on full.
module overflow_event_fifo
  import ovf_evt_pkg::*;
#(
  parameter int N      = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            count,
  input  logic                    overflow,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic                    ev_dir,
  output logic [TS_W-1:0]         ev_ts,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    full,
  output logic [DROP_W-1:0]       drop_cnt
);

  typedef struct packed {
    logic            dir;
    logic [TS_W-1:0] ts;
  } evt_rec_t;

  localparam int REC_W = $bits(evt_rec_t);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             cnt_zero;
  logic             cnt_ones;
  logic             evt_legal;
  logic             push_ok;
  evt_rec_t         wr_rec;
  evt_rec_t         head_rec;
  logic [REC_W-1:0] head_raw;

  always_comb begin
    ts_d      = ts_q + TS_W'(1);
    cnt_zero  = (count == '0);
    cnt_ones  = (count == '1);
    evt_legal = overflow && (cnt_zero || cnt_ones);
    wr_rec.dir = cnt_zero ? DIR_UP : DIR_DOWN;
    wr_rec.ts  = ts_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  ovf_evt_sync_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (evt_legal),
    .wr_data   (wr_rec),
    .wr_accept (push_ok),
    .rd_en     (ev_ready),
    .rd_valid  (ev_valid),
    .rd_data   (head_raw),
    .level     (level),
    .full      (full)
  );

  assign head_rec = evt_rec_t'(head_raw);
  assign ev_dir   = head_rec.dir;
  assign ev_ts    = head_rec.ts;

`ifdef OVF_EVT_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (evt_legal && !push_ok && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  // A wrap pulse must coincide with count at one of its two wrap values.
  a_ovf_legal: assert property (@(posedge clk) disable iff (rst)
    overflow |-> (cnt_zero || cnt_ones));

  // A legal event is only refused when full and nothing is popped.
  a_drop_only_full: assert property (@(posedge clk) disable iff (rst)
    (evt_legal && !push_ok) |-> (full && !(ev_valid && ev_ready)));

endmodule
